// File: rtl/ddr3_ui_pkg.sv
// ddr3_ui_pkg: shared constants, address helpers and FSM states
// for the DDR3 user-interface BRAM responder.
package ddr3_ui_pkg;

  localparam int DATA_W = 128;
  localparam int MASK_W = 16;
  localparam int ADDR_W = 28;

  localparam logic [2:0] DDR3_CMD_WR = 3'd0;
  localparam logic [2:0] DDR3_CMD_RD = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_WAIT,
    ST_DATA_HELD
  } ui_state_t;

  // {bank, row_col[23:3]}; rank bit and burst offset dropped
  function automatic logic [23:0] beat_full(
    input logic [ADDR_W-1:0] a
  );
    return {a[26:24], a[23:3]};
  endfunction

  function automatic logic misaligned(
    input logic [ADDR_W-1:0] a
  );
    return a[2:0] != 3'd0;
  endfunction

endpackage

// File: rtl/ddr3_ui_bram_responder_if.sv
// ddr3_ui_bram_responder_if: DDR3 UI command, write and read bundle.
// master drives commands and write beats; slave returns read beats.
interface ddr3_ui_bram_responder_if;
  import ddr3_ui_pkg::*;

  logic [2:0]        i_ddr3_cmd;
  logic              i_ddr3_cmd_en;
  logic [ADDR_W-1:0] i_ddr3_addr;
  logic [DATA_W-1:0] i_ddr3_wr_data;
  logic              i_ddr3_wr_data_en;
  logic              i_ddr3_wr_data_end;
  logic [MASK_W-1:0] i_ddr3_wr_mask;
  logic              o_ddr3_cmd_ready;
  logic              o_ddr3_wr_data_rdy;
  logic [DATA_W-1:0] o_ddr3_rd_data;
  logic              o_ddr3_rd_data_de;
  logic              o_ddr3_rd_data_end;
  logic              o_ddr3_error;

  modport master (
    output i_ddr3_cmd, i_ddr3_cmd_en,
    output i_ddr3_addr, i_ddr3_wr_data,
    output i_ddr3_wr_data_en,
    output i_ddr3_wr_data_end,
    output i_ddr3_wr_mask,
    input  o_ddr3_cmd_ready,
    input  o_ddr3_wr_data_rdy,
    input  o_ddr3_rd_data,
    input  o_ddr3_rd_data_de,
    input  o_ddr3_rd_data_end,
    input  o_ddr3_error
  );

  modport slave (
    input  i_ddr3_cmd, i_ddr3_cmd_en,
    input  i_ddr3_addr, i_ddr3_wr_data,
    input  i_ddr3_wr_data_en,
    input  i_ddr3_wr_data_end,
    input  i_ddr3_wr_mask,
    output o_ddr3_cmd_ready,
    output o_ddr3_wr_data_rdy,
    output o_ddr3_rd_data,
    output o_ddr3_rd_data_de,
    output o_ddr3_rd_data_end,
    output o_ddr3_error
  );

endinterface

// File: rtl/ddr3_ui_bram.sv
// ddr3_ui_bram: simple dual-port 128-bit RAM with byte enables,
// registered read and write-first bypass on address collision.
module ddr3_ui_bram
  import ddr3_ui_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [MASK_W-1:0] be,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int b = 0; b < MASK_W; b++) begin
      if (we && be[b])
        mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      if (we && be[b] && waddr == raddr)
        rdata[8*b +: 8] <= wdata[8*b +: 8];
      else
        rdata[8*b +: 8] <= mem[raddr][8*b +: 8];
    end
  end

endmodule

// File: rtl/ddr3_ui_bram_responder.sv
// ddr3_ui_bram_responder: DDR3 UI responder backed by on-chip RAM.
// Fixed read latency, optional refresh windows, sticky error flag.
module ddr3_ui_bram_responder
  import ddr3_ui_pkg::*;
#(
  parameter int MEM_AW         = 10,
  parameter int RD_LATENCY     = 8,
  parameter int REFRESH_PERIOD = 0,
  parameter int REFRESH_CYCLES = 4,
  parameter int WR_TIMEOUT     = 16
) (
  input logic clk,
  input logic rst,
  ddr3_ui_bram_responder_if.slave ui
);

  localparam logic [31:0] RP =
    32'(REFRESH_PERIOD);
  localparam logic [31:0] RC =
    32'(REFRESH_CYCLES);
  localparam logic [15:0] TO_LAST =
    16'(WR_TIMEOUT - 1);

  ui_state_t state, state_n;
  logic cmd_ready, wr_rdy;
  logic err, err_n;
  logic cmd_legal, cmd_ok;
  logic cmd_wr, cmd_rd, beat;
  logic hold_beat, to_hit, push;
  logic [MEM_AW-1:0] cmd_idx;
  logic [MEM_AW-1:0] wait_idx, wait_idx_n;
  logic [15:0] timer, timer_n;
  logic [DATA_W-1:0] held_data;
  logic [MASK_W-1:0] held_mask;
  logic we;
  logic [MEM_AW-1:0] widx;
  logic [DATA_W-1:0] wdata, ram_q, dtap;
  logic [MASK_W-1:0] wmask;
  logic [31:0] ref_cnt, ref_cnt_n;
  logic [31:0] ref_left, ref_left_n;
  logic ref_pend, ref_pend_n;
  logic ref_wrap, ref_now, ref_start;
  logic [RD_LATENCY-2:0] vsh, vsh_n;
  logic rd_de;
  logic [DATA_W-1:0] rd_q;

  assign cmd_idx =
    MEM_AW'(beat_full(ui.i_ddr3_addr));

  always_comb begin
    cmd_legal =
      (ui.i_ddr3_cmd == DDR3_CMD_WR) ||
      (ui.i_ddr3_cmd == DDR3_CMD_RD);
    cmd_ok = ui.i_ddr3_cmd_en &&
      cmd_ready && cmd_legal;
    cmd_wr = cmd_ok &&
      (ui.i_ddr3_cmd == DDR3_CMD_WR);
    cmd_rd = cmd_ok &&
      (ui.i_ddr3_cmd == DDR3_CMD_RD);
    beat = ui.i_ddr3_wr_data_en && wr_rdy;
  end

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    wait_idx_n = wait_idx;
    we         = 1'b0;
    widx       = cmd_idx;
    wdata      = ui.i_ddr3_wr_data;
    wmask      = ui.i_ddr3_wr_mask;
    hold_beat  = 1'b0;
    to_hit     = 1'b0;
    push       = cmd_rd;
    unique case (state)
      ST_IDLE: begin
        if (cmd_wr && beat) begin
          we = 1'b1;
        end else if (cmd_wr) begin
          state_n    = ST_WR_WAIT;
          timer_n    = 16'd0;
          wait_idx_n = cmd_idx;
        end else if (beat) begin
          hold_beat = 1'b1;
          state_n   = ST_DATA_HELD;
        end
      end
      ST_WR_WAIT: begin
        if (beat) begin
          we      = 1'b1;
          widx    = wait_idx;
          state_n = ST_IDLE;
        end else if (timer == TO_LAST) begin
          to_hit  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          timer_n = timer + 16'd1;
        end
      end
      ST_DATA_HELD: begin
        if (cmd_wr) begin
          we      = 1'b1;
          wdata   = held_data;
          wmask   = held_mask;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // windows only open from IDLE; a wrap elsewhere stays pending
  always_comb begin
    ref_wrap = (RP != 32'd0) &&
      (ref_cnt == RP - 32'd1);
    ref_cnt_n = (RP == 32'd0 || ref_wrap) ?
      32'd0 : ref_cnt + 32'd1;
    ref_now = ref_pend || ref_wrap;
    ref_start = ref_now &&
      (state_n == ST_IDLE) &&
      (ref_left == 32'd0);
    ref_pend_n = ref_now && !ref_start;
    if (ref_start)
      ref_left_n = RC;
    else if (ref_left != 32'd0)
      ref_left_n = ref_left - 32'd1;
    else
      ref_left_n = 32'd0;
  end

  always_comb begin
    err_n = err || to_hit;
    if (ui.i_ddr3_cmd_en && !cmd_ready)
      err_n = 1'b1;
    if (ui.i_ddr3_cmd_en && !cmd_legal)
      err_n = 1'b1;
    if (ui.i_ddr3_wr_data_en && !wr_rdy)
      err_n = 1'b1;
    if (ui.i_ddr3_wr_data_en !=
        ui.i_ddr3_wr_data_end)
      err_n = 1'b1;
    if (cmd_ok && misaligned(ui.i_ddr3_addr))
      err_n = 1'b1;
  end

  always_comb begin
    vsh_n    = vsh << 1;
    vsh_n[0] = push;
  end

  ddr3_ui_bram #(
    .AW (MEM_AW)
  ) u_bram (
    .clk   (clk),
    .we    (we),
    .waddr (widx),
    .wdata (wdata),
    .be    (~wmask),
    .raddr (cmd_idx),
    .rdata (ram_q)
  );

  // RAM output is one stage; the rest of the latency is a data shift
  if (RD_LATENCY == 2) begin : g_direct
    assign dtap = ram_q;
  end else begin : g_pipe
    logic [DATA_W-1:0] dsh [RD_LATENCY-2];
    always_ff @(posedge clk) begin
      dsh[0] <= ram_q;
      for (int k = 1; k < RD_LATENCY-2; k++)
        dsh[k] <= dsh[k-1];
    end
    assign dtap = dsh[RD_LATENCY-3];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      wr_rdy    <= 1'b0;
      err       <= 1'b0;
      timer     <= '0;
      wait_idx  <= '0;
      held_data <= '0;
      held_mask <= '0;
      ref_cnt   <= '0;
      ref_left  <= '0;
      ref_pend  <= 1'b0;
      vsh       <= '0;
      rd_de     <= 1'b0;
      rd_q      <= '0;
    end else begin
      state     <= state_n;
      cmd_ready <= (state_n != ST_WR_WAIT) &&
        (ref_left_n == 32'd0);
      wr_rdy    <= state_n != ST_DATA_HELD;
      err       <= err_n;
      timer     <= timer_n;
      wait_idx  <= wait_idx_n;
      if (hold_beat) begin
        held_data <= ui.i_ddr3_wr_data;
        held_mask <= ui.i_ddr3_wr_mask;
      end
      ref_cnt   <= ref_cnt_n;
      ref_left  <= ref_left_n;
      ref_pend  <= ref_pend_n;
      vsh       <= vsh_n;
      rd_de     <= vsh[RD_LATENCY-2];
      if (vsh[RD_LATENCY-2])
        rd_q <= dtap;
    end
  end

  assign ui.o_ddr3_cmd_ready   = cmd_ready;
  assign ui.o_ddr3_wr_data_rdy = wr_rdy;
  assign ui.o_ddr3_rd_data     = rd_q;
  assign ui.o_ddr3_rd_data_de  = rd_de;
  assign ui.o_ddr3_rd_data_end = rd_de;
  assign ui.o_ddr3_error       = err;

endmodule
